// File: rtl/div_seq_ctrl.sv
// rtl/div_seq_ctrl.sv - request/response sequencer for the 8-bit shift-subtract divider
// Optional feature: define SIGNED_DIV_EN for two's-complement requests (in_signed).
module div_seq_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  input  logic       in_signed,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_q,
  output logic [7:0] out_r,
  output logic       out_dbz,
  output logic       out_timeout,
  output logic       div_start,
  output logic [7:0] div_a,
  output logic [7:0] div_b,
  input  logic [7:0] div_q,
  input  logic [7:0] div_r,
  input  logic       div_done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_FIX   = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       mag_a;
  logic [7:0]       mag_b;
  logic             go_fix;

`ifdef SIGNED_DIV_EN
  // Sign corrections to apply in FIX, decided from the operands at accept time
  logic neg_q;
  logic neg_r;
  logic sgn_r;

  // Divider only sees magnitudes of signed operands; |-128| wraps to 8'h80
  always_comb begin
    mag_a = (in_signed && in_a[7]) ? 8'(~in_a + 8'd1) : in_a;
    mag_b = (in_signed && in_b[7]) ? 8'(~in_b + 8'd1) : in_b;
  end

  assign go_fix = sgn_r;
`else
  logic unused_signed;

  assign unused_signed = in_signed;
  assign mag_a         = in_a;
  assign mag_b         = in_b;
  assign go_fix        = 1'b0;
`endif

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_HOLD);
  assign div_start = (state == S_ISSUE);

  // Main sequencer: accept, issue, wait for done or timeout, fix sign, hold result
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      out_q       <= 8'd0;
      out_r       <= 8'd0;
      out_dbz     <= 1'b0;
      out_timeout <= 1'b0;
      div_a       <= 8'd0;
      div_b       <= 8'd0;
`ifdef SIGNED_DIV_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      sgn_r       <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            out_timeout <= 1'b0;
            if (in_b == 8'd0) begin
              // Divide-by-zero never touches the divider
              out_q   <= 8'hFF;
              out_r   <= in_a;
              out_dbz <= 1'b1;
              state   <= S_HOLD;
            end else begin
              out_dbz <= 1'b0;
              div_a   <= mag_a;
              div_b   <= mag_b;
`ifdef SIGNED_DIV_EN
              sgn_r   <= in_signed;
              neg_q   <= in_signed & (in_a[7] ^ in_b[7]);
              neg_r   <= in_signed & in_a[7];
`endif
              state   <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          // A done seen in the first WAIT cycle belongs to the previous operation
          if (div_done && (cnt != '0)) begin
            out_q <= div_q;
            out_r <= div_r;
            state <= go_fix ? S_FIX : S_HOLD;
          end else if (cnt == CNT_LAST) begin
            out_q       <= 8'd0;
            out_r       <= 8'd0;
            out_timeout <= 1'b1;
            state       <= S_HOLD;
          end
        end
        S_FIX: begin
`ifdef SIGNED_DIV_EN
          if (neg_q) out_q <= 8'd0 - out_q;
          if (neg_r) out_r <= 8'd0 - out_r;
`endif
          state <= S_HOLD;
        end
        S_HOLD: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb/tb_div_seq_ctrl.sv - randomized self-checking bench for div_seq_ctrl
module tb_div_seq_ctrl;

  localparam int TO = 16;
`ifdef SIGNED_DIV_EN
  localparam bit SGN_EN = 1'b1;
`else
  localparam bit SGN_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       in_signed;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_q;
  logic [7:0] out_r;
  logic       out_dbz;
  logic       out_timeout;
  logic       div_start;
  logic [7:0] div_a;
  logic [7:0] div_b;
  logic [7:0] div_q;
  logic [7:0] div_r;
  logic       div_done;

  int n_checks = 0;
  int n_errors = 0;

  // Divider model: 0 = done pulse lat cycles after start, 1 = hung, 2 = done held high
  int dmode = 0;
  int dlat  = 9;
  int dk    = 0;
  bit dbusy = 1'b0;

  always #5 clk = ~clk;

  div_seq_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_q(out_q), .out_r(out_r), .out_dbz(out_dbz), .out_timeout(out_timeout),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_q(div_q), .div_r(div_r), .div_done(div_done)
  );

  // Behavioural divider
  always @(posedge clk) begin
    if (rst) begin
      div_done <= 1'b0;
      dbusy    <= 1'b0;
      dk       <= 0;
    end else if (dmode == 2) begin
      div_done <= 1'b1;
      div_q    <= (div_b != 0) ? div_a / div_b : 8'h00;
      div_r    <= (div_b != 0) ? div_a % div_b : 8'h00;
    end else if (div_start) begin
      dbusy    <= (dmode == 0);
      dk       <= 1;
      div_done <= 1'b0;
      div_q    <= div_a / div_b;
      div_r    <= div_a % div_b;
    end else if (dbusy) begin
      dk       <= dk + 1;
      div_done <= (dk + 1 == dlat);
      if (dk + 1 == dlat) dbusy <= 1'b0;
    end else begin
      div_done <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input bit sg,
                       input int mode, input int lat, input int hold);
    logic [7:0] eq, er, ema, emb;
    bit edbz, eto, sact;
    int elat, cyc, starts, sa, sb;
    sact = SGN_EN && sg;
    sa   = sact ? int'($signed(a)) : int'(a);
    sb   = sact ? int'($signed(b)) : int'(b);
    ema  = 8'(sa < 0 ? -sa : sa);
    emb  = 8'(sb < 0 ? -sb : sb);
    edbz = 1'b0;
    eto  = 1'b0;
    if (b == 8'd0) begin
      eq = 8'hFF; er = a; edbz = 1'b1; elat = 1;
    end else if (mode == 1) begin
      eq = 8'h00; er = 8'h00; eto = 1'b1; elat = TO + 2;
    end else begin
      eq   = 8'(sa / sb);
      er   = 8'(sa % sb);
      elat = ((mode == 2) ? 4 : lat + 2) + (sact ? 1 : 0);
    end
    dmode = mode;
    dlat  = lat;
    @(negedge clk);
    in_a = a; in_b = b; in_signed = sg; in_valid = 1'b1; out_ready = 1'b0;
    check("in_ready_idle", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    cyc = 0;
    starts = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if (out_valid) break;
      if (div_start) begin
        starts++;
        check("div_a", div_a, ema);
        check("div_b", div_b, emb);
      end
    end
    check("latency", cyc, elat);
    check("start_count", starts, (b == 8'd0) ? 0 : 1);
    check("out_q", out_q, eq);
    check("out_r", out_r, er);
    check("out_dbz", out_dbz, edbz);
    check("out_timeout", out_timeout, eto);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_stable", {out_valid, in_ready, out_q, out_r, out_dbz, out_timeout},
            {1'b1, 1'b0, eq, er, edbz, eto});
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("released", {out_valid, in_ready}, 2'b01);
    dmode = 0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = 8'd0; in_b = 8'd0; in_signed = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ctl", {in_ready, out_valid, div_start, out_dbz, out_timeout}, 5'b10000);
    check("reset_data", {out_q, out_r, div_a, div_b}, 32'd0);
    rst = 1'b0;

    do_op(8'd100, 8'd7, 1'b0, 0, 9, 0);
    do_op(8'd5, 8'd0, 1'b0, 0, 9, 0);
    do_op(8'd200, 8'd3, 1'b0, 0, 9, 5);
    do_op(8'd77, 8'd5, 1'b0, 1, 9, 0);
    do_op(8'd77, 8'd5, 1'b0, 2, 9, 1);
    do_op(8'd30, 8'd4, 1'b0, 0, 16, 0);
    do_op(8'hF9, 8'd2, 1'b1, 0, 9, 0);
    do_op(8'h80, 8'hFF, 1'b1, 0, 9, 0);
    do_op(8'h85, 8'd0, 1'b1, 0, 9, 0);

    // Reset while the divider is hung in WAIT
    dmode = 1;
    @(negedge clk);
    in_a = 8'd50; in_b = 8'd3; in_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_ctl", {in_ready, out_valid, div_start, out_dbz, out_timeout}, 5'b10000);
    check("rst_mid_data", {out_q, out_r, div_a, div_b}, 32'd0);
    rst = 1'b0;
    dmode = 0;
    do_op(8'd9, 8'd4, 1'b0, 0, 9, 0);

    for (int n = 0; n < 40; n++) begin
      logic [7:0] ra, rb;
      int rm, md;
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      rm = int'($urandom_range(0, 9));
      md = (rm == 8) ? 1 : (rm == 9) ? 2 : 0;
      do_op(ra, rb, 1'($urandom), md, int'($urandom_range(2, 16)), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
